// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: state encoding and delivered-word counter width shared by the FIFO read controller
package fifo_rd_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, HOLD = 2'd2} state_t;
    localparam int RD_COUNT_W = 16;
endpackage

// File: rtl/fifo_rd_buf.sv
// fifo_rd_buf: circular output buffer with push/pop and an occupancy count
module fifo_rd_buf #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [AW:0]           count
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    always_comb begin
        mem_d = mem_q;
        mem_d[wr_ptr_q] = push ? push_data : mem_q[wr_ptr_q];
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    assign out_data = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: issues FIFO reads only when the local buffer can absorb every in-flight word
module fifo_read_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int BUF_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RD_COUNT_W-1:0] rd_count,
    output logic [1:0]            state_o
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    state_t state_q, state_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [RD_COUNT_W-1:0] rd_count_q, rd_count_d;
    logic [CW-1:0] buf_count, inflight;
    logic space, pop, capture;
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(vld_q[i]);
        space = ({1'b0, buf_count} + {1'b0, inflight}) < (CW+1)'(BUF_DEPTH);
        rd_en = (state_q == STREAM) && fifo_enable && !fifo_empty && space;
        vld_d = RD_LATENCY'({vld_q, rd_en});
        capture = vld_q[RD_LATENCY-1];
        out_valid = buf_count != '0;
        pop = out_valid && out_ready;
        rd_count_d = rd_count_q + RD_COUNT_W'(pop);
        state_d = state_q == IDLE   ? ((fifo_enable && !fifo_almost_empty) ? STREAM : IDLE)
                : state_q == STREAM ? ((!fifo_enable || fifo_empty) ? IDLE : (!space ? HOLD : STREAM))
                :                     (!fifo_enable ? IDLE : (space ? STREAM : HOLD));
    end
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q <= IDLE;
            vld_q <= '0;
            rd_count_q <= '0;
        end else begin
            state_q <= state_d;
            vld_q <= vld_d;
            rd_count_q <= rd_count_d;
        end
    end
    fifo_rd_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
        .clk(rd_clk),
        .rst_n(rd_rst_n),
        .push(capture),
        .push_data(rd_data),
        .pop(pop),
        .out_data(out_data),
        .count(buf_count)
    );
    assign rd_count = rd_count_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: FIFO source model, output scoreboard, table-driven scenarios and corner-case sequences
module tb_fifo_read_ctrl;
    import fifo_rd_pkg::*;
    logic rd_clk = 1'b0;
    logic rd_rst_n, fifo_enable, out_ready, ae_force;
    logic fifo_empty, fifo_almost_empty, rd_en, out_valid;
    logic [11:0] rd_data, out_data;
    logic [15:0] rd_count;
    logic [1:0] state_o;
    logic [11:0] mem [256];
    logic [11:0] exp_q [$];
    int wr_idx = 0;
    int rd_idx = 0;
    int vectors = 0;
    int miscompares = 0;
    int reads_seen = 0;
    typedef struct {
        int nwords;
        logic ae;
        logic en;
        int cycles;
        logic [1:0] exp_state;
        int exp_delta;
        int exp_reads;
    } vec_t;
    vec_t tbl [5];

    fifo_read_ctrl dut (
        .rd_clk(rd_clk),
        .rd_rst_n(rd_rst_n),
        .fifo_enable(fifo_enable),
        .fifo_empty(fifo_empty),
        .fifo_almost_empty(fifo_almost_empty),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .rd_count(rd_count),
        .state_o(state_o)
    );

    always #5 rd_clk = ~rd_clk;
    assign fifo_empty = (wr_idx == rd_idx);
    assign fifo_almost_empty = ae_force || ((wr_idx - rd_idx) <= 1);
    always @(posedge rd_clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx[7:0]];
            rd_idx <= rd_idx + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int n);
        logic [11:0] w;
        for (int i = 0; i < n; i++) begin
            w = 12'($urandom);
            mem[wr_idx[7:0]] = w;
            exp_q.push_back(w);
            wr_idx++;
        end
    endtask

    task automatic tick();
        @(negedge rd_clk);
        if (rd_en) reads_seen++;
        chk("no_underflow", 32'(rd_en & fifo_empty), 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %0d, expected no word", out_data);
            end else chk("out_data", out_data, exp_q.pop_front());
        end
        @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rd_rst_n = 1'b0;
        #1;
        chk("rst_state", state_o, IDLE);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rd_count", rd_count, 0);
        exp_q.delete();
        wr_idx = rd_idx;
        tick();
        rd_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int base, pushed, n;
        rd_rst_n = 1'b1;
        fifo_enable = 1'b0;
        out_ready = 1'b1;
        ae_force = 1'b0;
        #2;
        do_reset();
        tbl[0] = '{6, 1'b0, 1'b1, 30, IDLE, 6, 6};
        tbl[1] = '{2, 1'b1, 1'b1, 20, IDLE, 0, 0};
        tbl[2] = '{5, 1'b0, 1'b0, 20, IDLE, 0, 0};
        tbl[3] = '{1, 1'b0, 1'b1, 20, IDLE, 0, 0};
        tbl[4] = '{3, 1'b0, 1'b1, 20, IDLE, 3, 3};
        foreach (tbl[k]) begin
            base = int'(rd_count);
            reads_seen = 0;
            push(tbl[k].nwords);
            ae_force = tbl[k].ae;
            fifo_enable = tbl[k].en;
            repeat (tbl[k].cycles) tick();
            chk("tbl_state", state_o, tbl[k].exp_state);
            chk("tbl_delivered", 32'(16'(rd_count - 16'(base))), tbl[k].exp_delta);
            chk("tbl_reads", reads_seen, tbl[k].exp_reads);
            chk("tbl_out_valid", out_valid, 0);
            fifo_enable = 1'b0;
            ae_force = 1'b0;
            exp_q.delete();
            wr_idx = rd_idx;
        end
        // Back-pressure: reads must stop once buffer plus in-flight fill up
        out_ready = 1'b0;
        reads_seen = 0;
        push(8);
        fifo_enable = 1'b1;
        repeat (20) tick();
        chk("hold_reads", reads_seen, 4);
        chk("hold_state", state_o, HOLD);
        chk("hold_out_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_drain(100);
        repeat (4) tick();
        chk("hold_end_state", state_o, IDLE);
        fifo_enable = 1'b0;
        // Enable dropped with exactly one read in flight
        base = int'(rd_count);
        reads_seen = 0;
        push(6);
        fifo_enable = 1'b1;
        tick();
        tick();
        chk("drop_reads_before", reads_seen, 1);
        fifo_enable = 1'b0;
        #1;
        chk("drop_rd_en", rd_en, 0);
        repeat (6) tick();
        chk("drop_state", state_o, IDLE);
        chk("drop_delivered", 32'(16'(rd_count - 16'(base))), 1);
        chk("drop_reads", reads_seen, 1);
        chk("drop_left", exp_q.size(), 5);
        exp_q.delete();
        wr_idx = rd_idx;
        // Counter wrap after 65537 deliveries
        do_reset();
        pushed = 0;
        push(16);
        pushed = 16;
        fifo_enable = 1'b1;
        n = 0;
        while ((pushed < 65537 || exp_q.size() != 0) && n < 70000) begin
            repeat (2) if (pushed < 65537 && (wr_idx - rd_idx) < 16) begin
                push(1);
                pushed++;
            end
            tick();
            n++;
        end
        chk("wrap_drain", exp_q.size(), 0);
        chk("wrap_count", rd_count, 1);
        repeat (3) tick();
        chk("wrap_state", state_o, IDLE);
        fifo_enable = 1'b0;
        // Reset with words buffered: nothing stale may emerge afterwards
        out_ready = 1'b0;
        push(3);
        fifo_enable = 1'b1;
        repeat (8) tick();
        chk("pre_rst_valid", out_valid, 1);
        rd_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", rd_count, 0);
        chk("mid_rst_state", state_o, IDLE);
        exp_q.delete();
        fifo_enable = 1'b0;
        tick();
        tick();
        rd_rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("post_rst_valid", out_valid, 0);
        push(2);
        fifo_enable = 1'b1;
        wait_drain(50);
        repeat (3) tick();
        chk("post_rst_count", rd_count, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
